// File: rtl/data_mem_be.sv
// rtl/data_mem_be.sv - byte-enabled data memory with fixed-latency load/store port
//
// Purpose: single-port word memory serving RISC-V style B/H/W/BU/HU loads and
// B/H/W stores. One request is in flight at a time. Stores commit and loads
// read on the accepting edge. The response appears LATENCY cycles later as a
// one-cycle strobe.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle and not in reset)
//   req_we, req_size     store flag and funct3 access size
//   req_addr, req_wdata  little-endian byte address; right-aligned store data
//   rsp_valid            one-cycle response strobe
//   rsp_rdata, rsp_err   extended load data / fault flag, both zero outside rsp_valid

module data_mem_be #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  // Entering WAIT with LATENCY-2 yields LATENCY-1 WAIT cycles before RESP.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [MEM_WORDS];

  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          addr_err;
  logic          size_err;
  logic          store_err;
  logic          req_err;
  logic [31:0]   rd_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   wr_data;

  assign accept = req_valid && req_ready;
  assign idx    = req_addr[AW+1:2];
  assign lane   = req_addr[1:0];

  // Any address bit above the memory's byte range faults rather than wrapping.
  assign addr_err = |(req_addr >> (AW + 2));

  always_comb begin
    size_err = 1'b0;
    case (req_size)
      3'b000, 3'b100: size_err = 1'b0;
      3'b001, 3'b101: size_err = req_addr[0];
      3'b010:         size_err = (lane != 2'b00);
      default:        size_err = 1'b1;
    endcase
  end

  // Unsigned sizes have no store form.
  assign store_err = req_we && req_size[2];
  assign req_err   = addr_err || size_err || store_err;

  // Load path: the word is read combinationally so the lane-selected,
  // extended value can be captured on the accepting edge.
  assign rd_word = mem[idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (req_size)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // Store path: replicate right-aligned data across lanes and let the
  // byte enables pick which lanes land.
  always_comb begin
    be      = 4'b0000;
    wr_data = req_wdata;
    case (req_size)
      3'b000: begin
        be      = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        be      = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        be      = 4'b1111;
        wr_data = req_wdata;
      end
      default: begin
        be      = 4'b0000;
        wr_data = req_wdata;
      end
    endcase
  end

  // Memory is never reset; a faulting store leaves it untouched.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_d   = req_err;
          rdata_d = (req_we || req_err) ? 32'd0 : ld_data;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      req_ready = 1'b1;
    end
    if (state_q == S_RESP && !rst) begin
      rsp_valid = 1'b1;
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_data_mem_be.sv
// tb/tb_data_mem_be.sv - self-checking bench for data_mem_be (LATENCY 1 and 4 instances)

module tb_data_mem_be;

  localparam int unsigned MW0 = 1024;
  localparam int unsigned MW1 = 16;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  always #5 clk = ~clk;

  data_mem_be #(.MEM_WORDS(MW0), .LATENCY(1)) dut_a (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  data_mem_be #(.MEM_WORDS(MW1), .LATENCY(4)) dut_b (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  int tests = 0;
  int fails = 0;

  // Reference model: byte-addressed memory plus response timestamps.
  int          e = 0;
  bit          pend      [2];
  int          rsp_cyc   [2];
  bit          idle_prev [2];
  int          acc_cnt   [2];
  logic [31:0] m_rdata   [2];
  bit          m_err     [2];
  bit          m_known   [2];
  logic [7:0]  mb        [2][4096];
  bit          kn        [2][4096];

  // Observed DUT activity.
  int          rsp_cnt    [2];
  int          dut_acc    [2];
  logic [31:0] last_rdata [2];
  logic        last_err   [2];
  bit          cmp_exp_v;

  function automatic int unsigned lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int unsigned mbytes(input int k);
    return (k == 0) ? 4 * MW0 : 4 * MW1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=0x%08h exp=0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_accept(input int k);
    logic [31:0] a;
    logic [31:0] val;
    logic [2:0]  sz;
    int unsigned n;
    bit          err;
    bit          known;
    a  = req_addr[k];
    sz = req_size[k];
    n  = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    err = 1'b0;
    if (a >= mbytes(k)) err = 1'b1;
    if (sz == 3'd3 || sz >= 3'd6) err = 1'b1;
    if (req_we[k] && sz >= 3'd4) err = 1'b1;
    if ((a & (n - 1)) != 0) err = 1'b1;
    val   = 32'd0;
    known = 1'b1;
    if (!err) begin
      if (req_we[k]) begin
        for (int i = 0; i < int'(n); i++) begin
          mb[k][a + i] = req_wdata[k][8*i +: 8];
          kn[k][a + i] = 1'b1;
        end
      end else begin
        for (int i = 0; i < int'(n); i++) begin
          val   = val | (32'(mb[k][a + i]) << (8 * i));
          known = known & kn[k][a + i];
        end
        if (sz < 3'd4 && n < 4 && val[8*n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
      end
    end
    m_rdata[k] = val;
    m_err[k]   = err;
    m_known[k] = known;
  endtask

  // Model advances on each rising edge using the inputs presented at it.
  always @(posedge clk) begin
    e = e + 1;
    for (int k = 0; k < 2; k++) begin
      if (pend[k] && e > rsp_cyc[k]) pend[k] = 1'b0;
      if (rst[k]) begin
        pend[k] = 1'b0;
      end else if (idle_prev[k] && req_valid[k]) begin
        model_accept(k);
        pend[k]    = 1'b1;
        rsp_cyc[k] = e + int'(lat(k)) - 1;
        acc_cnt[k] = acc_cnt[k] + 1;
      end
      idle_prev[k] = !pend[k];
    end
  end

  // Compare process: responses early in each cycle, ready just before the edge.
  initial begin : compare
    forever begin
      @(posedge clk);
      #3;
      for (int k = 0; k < 2; k++) begin
        cmp_exp_v = pend[k] && (e == rsp_cyc[k]) && !rst[k];
        chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'(cmp_exp_v));
        if (cmp_exp_v) begin
          chk($sformatf("rsp_err[%0d]", k), 32'(rsp_err[k]), 32'(m_err[k]));
          if (m_known[k]) chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], m_rdata[k]);
        end else begin
          chk($sformatf("idle_rdata[%0d]", k), rsp_rdata[k], 32'd0);
          chk($sformatf("idle_err[%0d]", k), 32'(rsp_err[k]), 32'd0);
        end
        if (rsp_valid[k] === 1'b1) begin
          rsp_cnt[k]    = rsp_cnt[k] + 1;
          last_rdata[k] = rsp_rdata[k];
          last_err[k]   = rsp_err[k];
        end
      end
      @(negedge clk);
      #4;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready[%0d]", k), 32'(req_ready[k]), 32'(idle_prev[k] && !rst[k]));
        if (req_valid[k] === 1'b1 && req_ready[k] === 1'b1) dut_acc[k] = dut_acc[k] + 1;
      end
    end
  end

  task automatic xact(input int k, input logic we, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int a0;
    int r0;
    int t;
    @(negedge clk);
    a0 = acc_cnt[k];
    r0 = rsp_cnt[k];
    req_we[k]    = we;
    req_size[k]  = sz;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    t = 0;
    while (acc_cnt[k] == a0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    req_valid[k] = 1'b0;
    chk({nm, "_accepted"}, 32'(acc_cnt[k] - a0), 32'd1);
    t = 0;
    while (rsp_cnt[k] == r0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_responded"}, 32'(rsp_cnt[k] - r0), 32'd1);
    chk({nm, "_rdata"}, last_rdata[k], exp_rd);
    chk({nm, "_err"}, 32'(last_err[k]), 32'(exp_err));
    chk({nm, "_model"}, m_rdata[k], exp_rd);
  endtask

  task automatic rand_req(input int k);
    case ($urandom_range(0, 6))
      0:       req_size[k] = 3'b000;
      1:       req_size[k] = 3'b001;
      2:       req_size[k] = 3'b010;
      3:       req_size[k] = 3'b100;
      4:       req_size[k] = 3'b101;
      default: req_size[k] = 3'($urandom_range(0, 7));
    endcase
    case ($urandom_range(0, 15))
      0:       req_addr[k] = $urandom;
      1:       req_addr[k] = mbytes(k) + $urandom_range(0, 7);
      default: req_addr[k] = $urandom_range(0, 63);
    endcase
    req_we[k]    = 1'($urandom_range(0, 1));
    req_wdata[k] = $urandom;
    req_valid[k] = ($urandom_range(0, 3) != 0);
    rst[k]       = ($urandom_range(0, 63) == 0);
  endtask

  initial begin : main
    int a0;
    int r0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;  req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_size[k] = 3'd0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
      pend[k] = 1'b0; rsp_cyc[k] = 0; idle_prev[k] = 1'b1; acc_cnt[k] = 0;
      rsp_cnt[k] = 0; dut_acc[k] = 0; last_rdata[k] = 32'd0; last_err[k] = 1'b0;
      m_rdata[k] = 32'd0; m_err[k] = 1'b0; m_known[k] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4096; i++) begin
        mb[k][i] = 8'd0;
        kn[k][i] = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    #1;
    chk("ready_in_reset", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    chk("ready_after_reset_a", 32'(req_ready[0]), 32'd1);
    chk("ready_after_reset_b", 32'(req_ready[1]), 32'd1);

    // LATENCY=1 directed accesses
    xact(0, 1'b1, 3'b010, 32'h40, 32'h8765_4321, 32'h0, 1'b0, "sw40");
    xact(0, 1'b0, 3'b000, 32'h40, 32'h0, 32'h0000_0021, 1'b0, "lb40");
    xact(0, 1'b0, 3'b000, 32'h43, 32'h0, 32'hFFFF_FF87, 1'b0, "lb43");
    xact(0, 1'b0, 3'b100, 32'h43, 32'h0, 32'h0000_0087, 1'b0, "lbu43");
    xact(0, 1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF_8765, 1'b0, "lh42");
    xact(0, 1'b0, 3'b101, 32'h42, 32'h0, 32'h0000_8765, 1'b0, "lhu42");
    xact(0, 1'b1, 3'b000, 32'h41, 32'hAA, 32'h0, 1'b0, "sb41");
    xact(0, 1'b0, 3'b010, 32'h40, 32'h0, 32'h8765_AA21, 1'b0, "lw40");
    xact(0, 1'b1, 3'b010, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b0, "sw0");
    xact(0, 1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, "lw42_err");
    xact(0, 1'b1, 3'b001, 32'h43, 32'hBEEF, 32'h0, 1'b1, "sh43_err");
    xact(0, 1'b1, 3'b011, 32'h40, 32'hFFFF_FFFF, 32'h0, 1'b1, "sz3_err");
    xact(0, 1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, 32'h0, 1'b1, "sbu_err");
    xact(0, 1'b1, 3'b000, 32'h1000, 32'h55, 32'h0, 1'b1, "sb1000_err");
    xact(0, 1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h0, 1'b1, "lw_hi_err");
    xact(0, 1'b0, 3'b010, 32'h40, 32'h0, 32'h8765_AA21, 1'b0, "lw40_after");
    xact(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0, "lw0_after");

    // LATENCY=4: continuous valid gives one acceptance per 5 cycles
    xact(1, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, "b_sw10");
    @(negedge clk);
    a0 = dut_acc[1];
    req_we[1] = 1'b0; req_size[1] = 3'b010; req_addr[1] = 32'h10; req_valid[1] = 1'b1;
    repeat (25) @(negedge clk);
    req_valid[1] = 1'b0;
    chk("b_hold_accepts", 32'(dut_acc[1] - a0), 32'd5);
    repeat (6) @(negedge clk);

    // LATENCY=4: reset two cycles after a store aborts the response only
    r0 = rsp_cnt[1];
    a0 = acc_cnt[1];
    req_we[1] = 1'b1; req_size[1] = 3'b010; req_addr[1] = 32'h10;
    req_wdata[1] = 32'h1234_5678; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("b_abort_accepted", 32'(acc_cnt[1] - a0), 32'd1);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk("b_ready_in_rst", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("b_ready_after_abort", 32'(req_ready[1]), 32'd1);
    repeat (8) @(negedge clk);
    chk("b_no_rsp_after_abort", 32'(rsp_cnt[1] - r0), 32'd0);
    xact(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_5678, 1'b0, "b_lw10");

    // Randomized traffic against the model
    for (int k = 0; k < 2; k++) begin
      repeat (700) begin
        @(negedge clk);
        rand_req(k);
      end
      @(negedge clk);
      rst[k] = 1'b0;
      req_valid[k] = 1'b0;
      repeat (10) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
